pipe_adder_tree: RTL and testbench

PIPE_ADDER_TREE -- requirements
Module: pipe_adder_tree

---
 rtl/adder_tree_pkg.sv | 36 +++
 rtl/adder_tree_level.sv | 52 +++++
 rtl/pipe_adder_tree.sv | 120 ++++++++++++
 tb/tb_pipe_adder_tree.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Sizing helpers shared by the pipelined adder tree and its level stages.
package adder_tree_pkg;

  function automatic int clog2_ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < n) r = i + 32'sd1;
    end
    return r;
  endfunction

  // A single element still gets one register stage.
  function automatic int tree_levels(input int arr_l);
    return (clog2_ceil(arr_l) < 32'sd1) ? 32'sd1 : clog2_ceil(arr_l);
  endfunction

  function automatic int sum_width(input int data_depth, input int arr_l);
    return data_depth + clog2_ceil(arr_l);
  endfunction

  function automatic int level_nodes(input int arr_l, input int lvl);
    int r;
    r = arr_l;
    for (int i = 0; i < 64; i++) begin
      if (i < lvl) r = (r + 32'sd1) / 32'sd2;
    end
    return r;
  endfunction

  // Node width grows one bit per level, capped at the full sum width.
  function automatic int level_width(input int data_depth, input int arr_l, input int lvl);
    return data_depth + ((lvl < clog2_ceil(arr_l)) ? lvl : clog2_ceil(arr_l));
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered pairwise-add stage of the adder tree; an odd leftover node
// is passed through width-extended.
module adder_tree_level #(
  parameter int IN_N   = 4,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 9,
  parameter int SIGNED = 0,
  localparam int OUT_N = (IN_N + 1) / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   in_valid,
  input  logic [IN_N*IN_W-1:0]   in_data,
  output logic                   out_valid,
  output logic [OUT_N*OUT_W-1:0] out_data
);

  logic [OUT_N*OUT_W-1:0] sum_s;

  for (genvar j = 0; j < OUT_N; j++) begin : g_node
    logic [OUT_W-1:0] a_s;
    logic [OUT_W-1:0] b_s;
    if (SIGNED != 0) begin : g_sext
      assign a_s = OUT_W'($signed(in_data[2*j*IN_W +: IN_W]));
    end else begin : g_zext
      assign a_s = OUT_W'(in_data[2*j*IN_W +: IN_W]);
    end
    if (2*j + 1 < IN_N) begin : g_pair
      if (SIGNED != 0) begin : g_sext
        assign b_s = OUT_W'($signed(in_data[(2*j+1)*IN_W +: IN_W]));
      end else begin : g_zext
        assign b_s = OUT_W'(in_data[(2*j+1)*IN_W +: IN_W]);
      end
    end else begin : g_odd
      assign b_s = '0;
    end
    assign sum_s[j*OUT_W +: OUT_W] = a_s + b_s;
  end

  // Stage register; every stage of the tree shares the same enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= sum_s;
    end
  end

endmodule

// File: rtl/pipe_adder_tree.sv
// Pipelined balanced adder tree with valid/ready flow control.
// Define PIPE_ADDER_TREE_ACC_EN to add an in_last-delimited group accumulator.
module pipe_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int DATA_DEPTH = 8,
  parameter int ARR_L      = 4,
  parameter int SIGNED     = 0,
  parameter int ACC_BITS   = 4,
  localparam int SUM_W     = sum_width(DATA_DEPTH, ARR_L),
  localparam int LEVELS    = tree_levels(ARR_L),
`ifdef PIPE_ADDER_TREE_ACC_EN
  localparam int OUT_W     = SUM_W + ACC_BITS
`else
  localparam int OUT_W     = SUM_W + 0 * ACC_BITS
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_DEPTH*ARR_L-1:0] in_data,
`ifdef PIPE_ADDER_TREE_ACC_EN
  input  logic                        in_last,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_W-1:0]            out_sum
);

  logic             en_s;
  logic             tree_v_s;
  logic [SUM_W-1:0] tree_q_s;

  // The whole pipeline freezes only when a result is waiting on the consumer.
  assign en_s     = rst || !(out_valid && !out_ready);
  assign in_ready = en_s;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int IN_N  = level_nodes(ARR_L, l - 1);
    localparam int IN_W  = level_width(DATA_DEPTH, ARR_L, l - 1);
    localparam int OUT_N = level_nodes(ARR_L, l);
    localparam int OUT_W_L = level_width(DATA_DEPTH, ARR_L, l);
    logic                       vin_s;
    logic [IN_N*IN_W-1:0]       din_s;
    logic                       v_s;
    logic [OUT_N*OUT_W_L-1:0]   q_s;
    if (l == 1) begin : g_first
      assign vin_s = in_valid;
      assign din_s = in_data;
    end else begin : g_next
      assign vin_s = g_lvl[l-1].v_s;
      assign din_s = g_lvl[l-1].q_s;
    end
    adder_tree_level #(
      .IN_N   (IN_N),
      .IN_W   (IN_W),
      .OUT_W  (OUT_W_L),
      .SIGNED (SIGNED)
    ) u_level (
      .clk       (clk),
      .rst       (rst),
      .en        (en_s),
      .in_valid  (vin_s),
      .in_data   (din_s),
      .out_valid (v_s),
      .out_data  (q_s)
    );
  end

  assign tree_v_s = g_lvl[LEVELS].v_s;
  assign tree_q_s = g_lvl[LEVELS].q_s;

`ifdef PIPE_ADDER_TREE_ACC_EN
  logic [LEVELS-1:0] last_r;
  logic [OUT_W-1:0]  acc_r;
  logic [OUT_W-1:0]  tree_ext_s;
  logic [OUT_W-1:0]  total_s;

  if (SIGNED != 0) begin : g_acc_sext
    assign tree_ext_s = OUT_W'($signed(tree_q_s));
  end else begin : g_acc_zext
    assign tree_ext_s = OUT_W'(tree_q_s);
  end
  assign total_s = acc_r + tree_ext_s;

  // in_last travels alongside its beat through the tree levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= '0;
    end else if (en_s) begin
      last_r <= (last_r << 1) | LEVELS'(in_last);
    end
  end

  // Group accumulator: emits the running total on the last beat, then restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r     <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (en_s) begin
      if (tree_v_s && last_r[LEVELS-1]) begin
        out_sum   <= total_s;
        out_valid <= 1'b1;
        acc_r     <= '0;
      end else if (tree_v_s) begin
        acc_r     <= total_s;
        out_valid <= 1'b0;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  assign out_valid = tree_v_s;
  assign out_sum   = tree_q_s;
`endif

endmodule

// File: tb/tb_pipe_adder_tree.sv
// Self-checking bench: an unsigned 4-lane tree and a signed 5-lane tree run
// against a queue-based model, plus directed literal cases.
module tb_pipe_adder_tree;

`ifdef PIPE_ADDER_TREE_ACC_EN
  localparam int ACC = 1;
  localparam int AB  = 4;
`else
  localparam int ACC = 0;
  localparam int AB  = 0;
`endif
  localparam int L0 = 2 + ACC;
  localparam int L1 = 3 + ACC;
  localparam int W0 = 10 + AB;
  localparam int W1 = 11 + AB;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready, in_last;
  logic [31:0]   d0;
  logic [39:0]   d1;
  logic          rdy0, rdy1, ov0, ov1;
  logic [W0-1:0] s0;
  logic [W1-1:0] s1;

  always #5 clk = ~clk;

  pipe_adder_tree #(.DATA_DEPTH(8), .ARR_L(4), .SIGNED(0), .ACC_BITS(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(d0),
`ifdef PIPE_ADDER_TREE_ACC_EN
    .in_last(in_last),
`endif
    .out_valid(ov0), .out_ready(out_ready), .out_sum(s0));

  pipe_adder_tree #(.DATA_DEPTH(8), .ARR_L(5), .SIGNED(1), .ACC_BITS(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(d1),
`ifdef PIPE_ADDER_TREE_ACC_EN
    .in_last(in_last),
`endif
    .out_valid(ov1), .out_ready(out_ready), .out_sum(s1));

  int nchk = 0;
  int npass = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    nchk++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic longint sum0(input logic [31:0] d);
    longint s;
    s = 0;
    for (int k = 0; k < 4; k++) s += longint'(d[k*8 +: 8]);
    return s;
  endfunction

  function automatic longint sum1(input logic [39:0] d);
    longint s;
    s = 0;
    for (int k = 0; k < 5; k++) s += longint'($signed(d[k*8 +: 8]));
    return s;
  endfunction

  function automatic longint wrap(input longint v, input int w, input bit sgn);
    longint m;
    m = (longint'(1) << w) - 1;
    m = v & m;
    if (sgn && m[w-1]) m -= (longint'(1) << w);
    return m;
  endfunction

  // Model: results in order, each tagged with how many pipeline advances it has seen.
  longint mval[2][16];
  int     mage[2][16];
  int     mhead[2];
  int     mcnt[2];
  longint mgrp[2];
  bit     mrst[2];
  bit     mon = 1'b0;

  task automatic model_step(input int id, input int lv, input int w, input bit sgn,
                            input logic ov, input longint osum, input logic irdy,
                            input longint insum);
    logic eov, erdy;
    int   h;
    h    = mhead[id];
    eov  = (mcnt[id] > 0) && (mage[id][h] == lv);
    chk($sformatf("out_valid%0d", id), longint'(ov), longint'(eov));
    erdy = rst || !(eov && !out_ready);
    chk($sformatf("in_ready%0d", id), longint'(irdy), longint'(erdy));
    if (eov && ov) chk($sformatf("out_sum%0d", id), osum, mval[id][h]);
    if (mrst[id]) chk($sformatf("out_sum_after_rst%0d", id), osum, 0);
    mrst[id] = rst;
    if (rst) begin
      mcnt[id] = 0;
      mhead[id] = 0;
      mgrp[id] = 0;
    end else if (erdy) begin
      if (eov && out_ready) begin
        mhead[id] = (h + 1) % 16;
        mcnt[id]--;
      end
      for (int i = 0; i < mcnt[id]; i++) mage[id][(mhead[id] + i) % 16]++;
      if (in_valid) begin
        mgrp[id] += insum;
        if (in_last) begin
          mval[id][(mhead[id] + mcnt[id]) % 16] = wrap(mgrp[id], w, sgn);
          mage[id][(mhead[id] + mcnt[id]) % 16] = 1;
          mcnt[id]++;
          mgrp[id] = 0;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon) begin
        model_step(0, L0, W0, 1'b0, ov0, longint'(s0), rdy0, sum0(d0));
        model_step(1, L1, W1, 1'b1, ov1, longint'($signed(s1)), rdy1, sum1(d1));
      end else if (rst) begin
        mon = 1'b1;
        for (int i = 0; i < 2; i++) begin
          mrst[i] = 1'b1; mcnt[i] = 0; mhead[i] = 0; mgrp[i] = 0;
        end
      end
    end
  end

  logic [31:0] dd0[8];
  logic [39:0] dd1[8];
  logic        dl[8];
  longint      x0[8];
  longint      x1[8];

  // Back-to-back beats with out_ready high; beat j must appear exactly L cycles later.
  task automatic run_dir(input string tag, input int m);
    int j0, j1;
    out_ready = 1'b1;
    for (int c = 0; c < m + L1 + 1; c++) begin
      @(posedge clk); #1;
      if (c < m) begin
        in_valid = 1'b1; d0 = dd0[c]; d1 = dd1[c]; in_last = dl[c];
      end else begin
        in_valid = 1'b0; in_last = 1'b1;
      end
      @(negedge clk);
      j0 = c - L0;
      j1 = c - L1;
      if (j0 >= 0 && j0 < m && dl[j0]) begin
        chk({tag, "_ov0"}, longint'(ov0), 1);
        chk({tag, "_sum0"}, longint'(s0), x0[j0]);
      end else chk({tag, "_ov0"}, longint'(ov0), 0);
      if (j1 >= 0 && j1 < m && dl[j1]) begin
        chk({tag, "_ov1"}, longint'(ov1), 1);
        chk({tag, "_sum1"}, longint'($signed(s1)), x1[j1]);
      end else chk({tag, "_ov1"}, longint'(ov1), 0);
    end
  endtask

  longint got[16];
  int     n, k;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b1; d0 = '0; d1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ov0", longint'(ov0), 0);
    chk("reset_sum0", longint'(s0), 0);
    chk("reset_ov1", longint'(ov1), 0);
    chk("reset_sum1", longint'(s1), 0);

    for (int i = 0; i < 8; i++) dl[i] = 1'b1;
    dd0[0] = 32'hFFFF_FFFF;   x0[0] = 1020;
    dd0[1] = 32'h0403_0201;   x0[1] = 10;
    dd1[0] = 40'h05_0403_0201; x1[0] = 15;
    dd1[1] = 40'h05_0505_0505; x1[1] = 25;
    run_dir("basic", 2);

    dd0[0] = 32'h0000_0000;   x0[0] = 0;
    dd0[1] = 32'h0100_00FF;   x0[1] = 256;
    dd1[0] = 40'h80_8080_8080; x1[0] = -640;
    dd1[1] = 40'h00_0100_FF7F; x1[1] = 127;
    run_dir("signed", 2);

`ifdef PIPE_ADDER_TREE_ACC_EN
    for (int i = 0; i < 3; i++) begin
      dd0[i] = 32'h0101_0101; dd1[i] = 40'h01_0101_0101; dl[i] = (i == 2);
    end
    x0[2] = 12; x1[2] = 15;
    run_dir("group", 3);
    for (int i = 0; i < 8; i++) dl[i] = 1'b1;
`endif

    // Stream k=1..8 with a three-cycle consumer stall in the middle.
    k = 1; n = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 5 && c < 8);
      in_valid  = (k <= 8);
      in_last   = 1'b1;
      d0 = {4{k[7:0]}};
      d1 = {5{k[7:0]}};
      @(negedge clk);
      if (c >= 5 && c < 8) chk("stall_in_ready0", longint'(rdy0), 0);
      if (ov0 && out_ready && n < 16) begin
        got[n] = longint'(s0);
        n++;
      end
      if (in_valid && rdy0) k++;
    end
    chk("stall_count", n, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("stall_out%0d", i), got[i], 4 * (i + 1));

    // Reset with beats in flight, a beat offered during reset, and the consumer stalled.
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; d0 = 32'h0909_0909; d1 = 40'h09_0909_0909;
    @(posedge clk); #1;
    d0 = 32'h0707_0707; d1 = 40'h07_0707_0707;
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0; d0 = 32'h0303_0303; d1 = 40'h03_0303_0303;
    @(negedge clk);
    chk("rst_in_ready0", longint'(rdy0), 1);
    chk("rst_in_ready1", longint'(rdy1), 1);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("flush_ov0", longint'(ov0), 0);
      chk("flush_ov1", longint'(ov1), 0);
    end
    dd0[0] = 32'h0202_0202;    x0[0] = 8;
    dd1[0] = 40'h02_0202_0202; x1[0] = 10;
    run_dir("after_rst", 1);

    // Random traffic, random back-pressure and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      d0        = $urandom();
      d1[31:0]  = $urandom();
      d1[39:32] = 8'($urandom());
`ifdef PIPE_ADDER_TREE_ACC_EN
      in_last   = ($urandom_range(0, 2) == 0);
`else
      in_last   = 1'b1;
`endif
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b1;
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
